// File: rtl/agc_op_sequencer.sv
// rtl/agc_op_sequencer.sv - multi-cycle one's-complement CS/AD/CCS/CMP sequencer
module agc_op_sequencer #(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       skip,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_CARRY = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] OP_CS  = 2'b00;
  localparam logic [1:0] OP_AD  = 2'b01;
  localparam logic [1:0] OP_CCS = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  // +0 is all zeros, -0 is all ones in one's complement
  localparam logic [WIDTH-1:0] ZERO_POS = '0;
  localparam logic [WIDTH-1:0] ZERO_NEG = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       opcode_q, opcode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       skip_q, skip_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] cs_val;
  logic [WIDTH:0]   raw_sum;
  logic [WIDTH-1:0] eac_val;
  logic             eac_ovf;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] ccs_val;
  logic [1:0]       ccs_skip;

  // Datapath: inverter, raw adder, end-around-carry fold, comparator, CCS classifier
  always_comb begin
    cs_val   = ~a_q;
    raw_sum  = {1'b0, a_q} + {1'b0, b_q};
    // carry out of the top bit wraps back into bit 0
    eac_val  = sum_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum_q[WIDTH]};
    eac_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (eac_val[WIDTH-1] != a_q[WIDTH-1]);
    cmp_val  = {{(WIDTH-1){1'b0}}, (a_q > b_q)};
    ccs_val  = '0;
    ccs_skip = 2'd0;
    if (a_q == ZERO_POS) begin
      ccs_val  = '0;
      ccs_skip = 2'd1;
    end else if (a_q == ZERO_NEG) begin
      ccs_val  = '0;
      ccs_skip = 2'd3;
    end else if (!a_q[WIDTH-1]) begin
      ccs_val  = a_q - ONE;
      ccs_skip = 2'd0;
    end else begin
      // magnitude of a negative word, minus one
      ccs_val  = cs_val - ONE;
      ccs_skip = 2'd2;
    end
  end

  // Next-state and register-update logic for the sequencing FSM
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    result_d   = result_q;
    skip_d     = skip_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          a_d      = operand_a;
          b_d      = operand_b;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (opcode_q == OP_AD) begin
          // outputs stay untouched until the carry has been folded in
          sum_d   = raw_sum;
          state_d = ST_CARRY;
        end else begin
          skip_d     = 2'd0;
          overflow_d = 1'b0;
          case (opcode_q)
            OP_CS:   result_d = cs_val;
            OP_CCS: begin
              result_d = ccs_val;
              skip_d   = ccs_skip;
            end
            OP_CMP:  result_d = cmp_val;
            default: result_d = cs_val;
          endcase
          state_d = ST_DONE;
        end
      end
      ST_CARRY: begin
        result_d   = eac_val;
        skip_d     = 2'd0;
        overflow_d = eac_ovf;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand/result registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      opcode_q   <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      skip_q     <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake flags decode straight from state so reset clears them at once
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    result   = result_q;
    skip     = skip_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_agc_op_sequencer.sv
// tb/tb_agc_op_sequencer.sv - scoreboard bench for agc_op_sequencer
module tb_agc_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  opcode;
  logic [14:0] operand_a;
  logic [14:0] operand_b;
  logic        busy;
  logic        done;
  logic [14:0] result;
  logic [1:0]  skip;
  logic        overflow;

  agc_op_sequencer #(.WIDTH(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .skip      (skip),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [14:0] r;
    logic [1:0]  s;
    logic        o;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          automatic exp_t e = exp_q.pop_front();
          chk("result",       {17'd0, result},   {17'd0, e.r});
          chk("skip",         {30'd0, skip},     {30'd0, e.s});
          chk("overflow",     {31'd0, overflow}, {31'd0, e.o});
          chk("done_cycle",   cyc,               e.c);
          chk("busy_at_done", {31'd0, busy},     32'd1);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk(name, exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Issue one op; operands are scrambled right after acceptance
  task automatic run_op(input logic [1:0] op, input logic [14:0] a, input logic [14:0] b,
                        input logic [14:0] er, input logic [1:0] es, input logic eo);
    exp_t e;
    @(negedge clk);
    opcode    = op;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    operand_a = 15'($urandom);
    operand_b = 15'($urandom);
    opcode    = 2'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    e.r = er;
    e.s = es;
    e.o = eo;
    e.c = cyc + ((op == 2'b01) ? 2 : 1);
    exp_q.push_back(e);
    wait_drain("done_timeout");
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    reset_n   = 1'b0;
    start     = 1'b0;
    opcode    = 2'b00;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_result",   {17'd0, result},   32'd0);
    chk("rst_skip",     {30'd0, skip},     32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // CS
    run_op(2'b00, 15'h72C2, 15'h0000, 15'h0D3D, 2'd0, 1'b0);
    // AD
    run_op(2'b01, 15'h0003, 15'h7FFD, 15'h0001, 2'd0, 1'b0);
    run_op(2'b01, 15'h7FFF, 15'h7FFF, 15'h7FFF, 2'd0, 1'b0);
    run_op(2'b01, 15'h3FFF, 15'h0001, 15'h4000, 2'd0, 1'b1);
    // CCS
    run_op(2'b10, 15'h0005, 15'h1111, 15'h0004, 2'd0, 1'b0);
    run_op(2'b10, 15'h0000, 15'h1111, 15'h0000, 2'd1, 1'b0);
    run_op(2'b10, 15'h7FFA, 15'h1111, 15'h0004, 2'd2, 1'b0);
    run_op(2'b10, 15'h7FFF, 15'h1111, 15'h0000, 2'd3, 1'b0);
    // CMP
    run_op(2'b11, 15'h72C2, 15'h0001, 15'h0001, 2'd0, 1'b0);
    run_op(2'b11, 15'h0001, 15'h72C2, 15'h0000, 2'd0, 1'b0);
    run_op(2'b11, 15'h2345, 15'h2345, 15'h0000, 2'd0, 1'b0);

    // start held during EXEC and DONE must be ignored
    @(negedge clk);
    opcode    = 2'b00;
    operand_a = 15'h1234;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.r = 15'h6DCB;
    e.s = 2'd0;
    e.o = 1'b0;
    e.c = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start     = 1'b1;
    operand_a = 15'h0000;
    @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ignore_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    chk("ignore_result_held", {17'd0, result}, {17'd0, 15'h6DCB});
    chk("ignore_busy_idle",   {31'd0, busy},   32'd0);

    // AD that reaches 4000/overflow, then reset lands in CARRY of the next AD
    run_op(2'b01, 15'h3FFF, 15'h0001, 15'h4000, 2'd0, 1'b1);
    @(negedge clk);
    opcode    = 2'b01;
    operand_a = 15'h3FFF;
    operand_b = 15'h0001;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy",     {31'd0, busy},     32'd0);
    chk("abort_done",     {31'd0, done},     32'd0);
    chk("abort_result",   {17'd0, result},   32'd0);
    chk("abort_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done_busy", {31'd0, busy}, 32'd0);

    run_op(2'b00, 15'h0F0F, 15'h0000, 15'h70F0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
